// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM pulse train in clk_in
// cycles and hands each result to a valid/ready consumer. A programmable
// timeout reports inputs that stay stuck high or stuck low.
module pwm_capture #(
    parameter int CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             enable,
    input  logic             pwm_in,
    input  logic [CNT_W-1:0] timeout_limit,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_cnt_out,
    output logic [CNT_W-1:0] period_cnt_out,
    output logic             stuck_out,
    output logic             overrun
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             pwm_d;
    logic             rise, fall;
    logic [CNT_W-1:0] period_cnt, high_cnt;
    logic [CNT_W-1:0] period_d, high_d;
    logic [CNT_W-1:0] eff_limit;
    logic             at_limit;
    logic             capture, cap_stuck;

    assign rise = pwm_in & ~pwm_d;
    assign fall = ~pwm_in & pwm_d;

    // A zero limit selects the largest count the counters can hold.
    assign eff_limit = (timeout_limit == '0) ? '1 : timeout_limit;

    // The >= keeps the counters bounded even if the limit is lowered below
    // the running count mid-period; it behaves as == otherwise.
    assign at_limit = ~rise && (period_cnt >= eff_limit);

    // Edge-detect register and FSM/counter state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pwm_d      <= 1'b0;
            state_q    <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            pwm_d      <= pwm_in;
            state_q    <= state_d;
            period_cnt <= period_d;
            high_cnt   <= high_d;
        end
    end

    // Next-state, counter update and capture request.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        period_d  = period_cnt;
        high_d    = high_cnt;
        capture   = 1'b0;
        cap_stuck = 1'b0;

        if (!enable) begin
            state_d  = IDLE;
            period_d = '0;
            high_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;

                // Waiting for a low level prevents a false rise when the
                // input is already high at enable or after a stuck-high report.
                ARM: begin
                    if (!pwm_d) state_d = WAIT_RISE;
                end

                // The rise cycle itself is the first high cycle.
                WAIT_RISE: begin
                    if (rise) begin
                        period_d = ONE;
                        high_d   = ONE;
                        state_d  = HIGH;
                    end
                end

                HIGH: begin
                    if (at_limit) begin
                        capture   = 1'b1;
                        cap_stuck = 1'b1;
                        period_d  = '0;
                        high_d    = '0;
                        state_d   = ARM;
                    end else if (fall) begin
                        period_d = period_cnt + ONE;
                        state_d  = LOW;
                    end else begin
                        period_d = period_cnt + ONE;
                        high_d   = high_cnt + ONE;
                    end
                end

                // A rise closes the period and also starts the next one.
                LOW: begin
                    if (rise) begin
                        capture  = 1'b1;
                        period_d = ONE;
                        high_d   = ONE;
                        state_d  = HIGH;
                    end else if (at_limit) begin
                        capture   = 1'b1;
                        cap_stuck = 1'b1;
                        period_d  = '0;
                        high_d    = '0;
                        state_d   = ARM;
                    end else begin
                        period_d = period_cnt + ONE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // Result registers, valid/ready handshake and sticky overrun flag.
    // A capture while an unaccepted result is held is dropped so the
    // consumer always sees a stable, self-consistent result.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            meas_valid     <= 1'b0;
            high_cnt_out   <= '0;
            period_cnt_out <= '0;
            stuck_out      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (capture) begin
                if (!meas_valid || meas_ready) begin
                    meas_valid     <= 1'b1;
                    high_cnt_out   <= high_cnt;
                    period_cnt_out <= period_cnt;
                    stuck_out      <= cap_stuck;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (meas_ready) begin
                meas_valid <= 1'b0;
            end

            if (!enable) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture: periodic inputs, backpressure,
// timeouts, enable while high, reset and enable abort mid-measurement.
module tb_pwm_capture;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable;
    logic        pwm_in;
    logic [31:0] timeout_limit;
    logic        meas_valid;
    logic        meas_ready;
    logic [31:0] high_cnt_out;
    logic [31:0] period_cnt_out;
    logic        stuck_out;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    // Observed tuple: {valid, stuck, overrun, high, period}
    wire  [66:0] obs = {meas_valid, stuck_out, overrun, high_cnt_out, period_cnt_out};
    logic [66:0] exp_t;

    pwm_capture #(.CNT_W(32)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .enable         (enable),
        .pwm_in         (pwm_in),
        .timeout_limit  (timeout_limit),
        .meas_valid     (meas_valid),
        .meas_ready     (meas_ready),
        .high_cnt_out   (high_cnt_out),
        .period_cnt_out (period_cnt_out),
        .stuck_out      (stuck_out),
        .overrun        (overrun)
    );

    always #5 clk_in = ~clk_in;

    function automatic string fmt(input logic [66:0] t);
        return $sformatf("v=%0b s=%0b o=%0b h=%0d p=%0d",
                         t[66], t[65], t[64], t[63:32], t[31:0]);
    endfunction

    // Present one input level for one cycle; outputs are sampled 1 ns after the edge.
    task automatic step(input logic v);
        pwm_in = v;
        @(posedge clk_in);
        #1;
    endtask

    task automatic steps(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Rest of a period whose rise step was already issued.
    task automatic tail(input int h, input int l);
        steps(1'b1, h - 1);
        steps(1'b0, l);
    endtask

    // Abort, re-enable and arm with the input low; ends in WAIT_RISE.
    task automatic restart();
        enable = 1'b0;
        step(1'b0);
        enable = 1'b1;
        steps(1'b0, 2);
    endtask

    task automatic test_reset();
        rst_in = 1'b1; enable = 1'b0; meas_ready = 1'b1;
        timeout_limit = 32'd100; pwm_in = 1'b0;
        steps(1'b0, 2);
        rst_in = 1'b0;
        exp_t = '0;
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL reset_state: got %s want %s", fmt(obs), fmt(exp_t));
        end
    endtask

    task automatic test_periodic_3_5();
        meas_ready = 1'b1;
        restart();
        step(1'b1);
        tail(3, 5);
        total++;
        if (meas_valid !== 1'b0) begin
            bad++; $display("FAIL p35_partial: got valid=%0b want 0", meas_valid);
        end
        step(1'b1);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL p35_first: got %s want %s", fmt(obs), fmt(exp_t));
        end
        tail(3, 5);
        total++;
        if (meas_valid !== 1'b0) begin
            bad++; $display("FAIL p35_accept: got valid=%0b want 0", meas_valid);
        end
        step(1'b1);
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL p35_second: got %s want %s", fmt(obs), fmt(exp_t));
        end
    endtask

    task automatic test_periodic_1_1();
        meas_ready = 1'b1;
        restart();
        step(1'b1);
        step(1'b0);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd1, 32'd2};
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            total++;
            if (obs !== exp_t) begin
                bad++; $display("FAIL p11_result%0d: got %s want %s", k, fmt(obs), fmt(exp_t));
            end
            step(1'b0);
            total++;
            if (meas_valid !== 1'b0) begin
                bad++; $display("FAIL p11_accept%0d: got valid=%0b want 0", k, meas_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        meas_ready = 1'b1;
        restart();
        step(1'b1);
        tail(3, 5);
        step(1'b1);
        meas_ready = 1'b0;
        tail(2, 4);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL bp_held: got %s want %s", fmt(obs), fmt(exp_t));
        end
        step(1'b1);
        exp_t = {1'b1, 1'b0, 1'b1, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL bp_dropped: got %s want %s", fmt(obs), fmt(exp_t));
        end
        meas_ready = 1'b1;
        step(1'b1);
        meas_ready = 1'b0;
        exp_t = {1'b0, 1'b0, 1'b1, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL bp_accept: got %s want %s", fmt(obs), fmt(exp_t));
        end
        step(1'b1);
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL bp_sticky: got overrun=%0b want 1", overrun);
        end
        enable = 1'b0;
        step(1'b1);
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL bp_clear: got overrun=%0b want 0", overrun);
        end
        meas_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        meas_ready = 1'b1;
        restart();
        step(1'b1);
        tail(3, 5);
        meas_ready = 1'b0;
        step(1'b1);
        tail(2, 4);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL b2b_first: got %s want %s", fmt(obs), fmt(exp_t));
        end
        meas_ready = 1'b1;
        step(1'b1);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd2, 32'd6};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL b2b_reload: got %s want %s", fmt(obs), fmt(exp_t));
        end
    endtask

    task automatic test_timeout_low();
        int seen;
        meas_ready = 1'b1;
        timeout_limit = 32'd20;
        restart();
        step(1'b1);
        steps(1'b1, 3);
        steps(1'b0, 16);
        total++;
        if (meas_valid !== 1'b0) begin
            bad++; $display("FAIL tol_early: got valid=%0b want 0", meas_valid);
        end
        step(1'b0);
        exp_t = {1'b1, 1'b1, 1'b0, 32'd4, 32'd20};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL tol_result: got %s want %s", fmt(obs), fmt(exp_t));
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0);
            if (meas_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL tol_quiet: got %0d results want 0", seen);
        end
        step(1'b1);
        tail(3, 5);
        step(1'b1);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL tol_rearm: got %s want %s", fmt(obs), fmt(exp_t));
        end
        timeout_limit = 32'd100;
    endtask

    task automatic test_timeout_high();
        int seen;
        meas_ready = 1'b1;
        timeout_limit = 32'd6;
        restart();
        step(1'b1);
        steps(1'b1, 5);
        total++;
        if (meas_valid !== 1'b0) begin
            bad++; $display("FAIL toh_early: got valid=%0b want 0", meas_valid);
        end
        step(1'b1);
        exp_t = {1'b1, 1'b1, 1'b0, 32'd6, 32'd6};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL toh_result: got %s want %s", fmt(obs), fmt(exp_t));
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (meas_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL toh_quiet: got %0d results want 0", seen);
        end
        timeout_limit = 32'd100;
    endtask

    task automatic test_high_at_enable();
        int seen;
        meas_ready = 1'b1;
        enable = 1'b0;
        steps(1'b1, 2);
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            if (meas_valid === 1'b1) seen++;
        end
        steps(1'b0, 4);
        step(1'b1);
        tail(3, 5);
        if (meas_valid === 1'b1) seen++;
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL hae_false: got %0d results want 0", seen);
        end
        step(1'b1);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL hae_result: got %s want %s", fmt(obs), fmt(exp_t));
        end
    endtask

    task automatic test_reset_mid();
        meas_ready = 1'b1;
        restart();
        meas_ready = 1'b0;
        step(1'b1);
        tail(3, 5);
        step(1'b1);
        step(1'b1);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL rm_before: got %s want %s", fmt(obs), fmt(exp_t));
        end
        rst_in = 1'b1;
        step(1'b1);
        rst_in = 1'b0;
        exp_t = '0;
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL rm_cleared: got %s want %s", fmt(obs), fmt(exp_t));
        end
        steps(1'b1, 2);
        steps(1'b0, 3);
        step(1'b1);
        tail(3, 5);
        total++;
        if (meas_valid !== 1'b0) begin
            bad++; $display("FAIL rm_partial: got valid=%0b want 0", meas_valid);
        end
        step(1'b1);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL rm_after: got %s want %s", fmt(obs), fmt(exp_t));
        end
        meas_ready = 1'b1;
    endtask

    task automatic test_enable_abort();
        meas_ready = 1'b1;
        restart();
        meas_ready = 1'b0;
        step(1'b1);
        tail(3, 5);
        step(1'b1);
        step(1'b1);
        enable = 1'b0;
        step(1'b1);
        steps(1'b0, 2);
        step(1'b1);
        tail(2, 4);
        step(1'b1);
        exp_t = {1'b1, 1'b0, 1'b0, 32'd3, 32'd8};
        total++;
        if (obs !== exp_t) begin
            bad++; $display("FAIL ea_retained: got %s want %s", fmt(obs), fmt(exp_t));
        end
        meas_ready = 1'b1;
        step(1'b0);
        total++;
        if (meas_valid !== 1'b0) begin
            bad++; $display("FAIL ea_accept: got valid=%0b want 0", meas_valid);
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_periodic_3_5();
        test_periodic_1_1();
        test_backpressure();
        test_back_to_back();
        test_timeout_low();
        test_timeout_high();
        test_high_at_enable();
        test_reset_mid();
        test_enable_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
